encrip_stream: RTL and testbench
================================

# encrip_stream

Parametrised, streaming successor to the team's fixed 3-bit substitution encoder. Each accepted input symbol is mapped through a programmable substitution table. The table index is offset by a key that can rotate on every symbol. The result is held in a registered output stage with valid/ready handshakes on both sides. The block sits between the symbol source and the link framer, and the control processor can reprogram the table in place.

## Interface
- DIN_W, 3: input symbol width; the table has 2**DIN_W entries.
- DOUT_W, 5: output code width.
- KEY_STEP, 1: amount added to the key after each accepted symbol in rotate mode (mod 2**DIN_W).
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- mode  in  1  0 = static key, 1 = rotating key; sampled at each input acceptance.
- key_load  in  1  load key_in into the key register (RUN state only).
- key_in  in  DIN_W  key value to load.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  block can accept a symbol.
- din  in  DIN_W  input symbol.
- out_valid  out  1  dout holds a code.
- out_ready  in  1  downstream accepts dout.
- dout  out  DOUT_W  encoded symbol.
- prog_start  in  1  request table reprogramming.
- prog_valid  in  1  prog_data holds a table entry.
- prog_data  in  DOUT_W  table entry value.
- prog_done  out  1  one-cycle pulse when the last entry is written.
- busy  out  1  high in the DRAIN and PROG states.

## Operation
- Reset values:
  - state = RUN; key = 0; out_valid = 0; dout = 0; prog_done = 0; write address = 0.
  - table[i] = (7*i + 7) mod 2**DOUT_W. For the defaults this gives 7,14,21,28,3,10,17,24.
- RUN state:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready. Then idx = (din + key) mod 2**DIN_W, and dout <= table[idx], out_valid <= 1.
  - If mode = 1 on acceptance, key <= (key + KEY_STEP) mod 2**DIN_W. The new key applies to the next symbol.
  - If out_ready && out_valid and no acceptance in the same cycle, out_valid <= 0.
  - key_load has priority over rotation in the same cycle. The accepted symbol still uses the old key.
- prog_start in RUN:
  - If out_valid = 0, go to PROG.
  - Otherwise go to DRAIN.
  - The symbol accepted in that same cycle is still processed.
- DRAIN state: in_ready = 0. Go to PROG on the cycle where out_valid falls to 0.
- PROG state:
  - in_ready = 0; key_load is ignored.
  - Each prog_valid beat writes table[addr] <= prog_data, then addr increments.
  - The write at addr = 2**DIN_W-1 pulses prog_done, resets addr to 0 and returns to RUN.
  - prog_start is ignored outside RUN.
- Key and mode are unchanged by programming.
- Reset asserted at any time (mid-PROG, mid-DRAIN, during a held output) returns every register to its reset value immediately. This includes restoring the default table. No partial program is retained.

## Timing
- Latency: dout/out_valid are valid 1 cycle after acceptance.
- Throughput: 1 symbol/cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, dout and out_valid are held stable and in_ready = 0.
- in_ready is combinational from out_valid, out_ready and state. There is no combinational path from in_valid to out_valid.
- Programming: exactly 2**DIN_W prog_valid beats; RUN resumes the cycle after the prog_done pulse.
- A table write becomes visible to the first symbol accepted in RUN after prog_done.
- Key wrap: the key adds modulo 2**DIN_W. For example, 7+1 → 0 at DIN_W=3.

## Test plan
- Static mode: reset, mode=0, out_ready=1, din 0..7 on consecutive cycles → dout 7,14,21,28,3,10,17,24, each one cycle after its input, out_valid continuously high.
- Rotate mode: mode=1, KEY_STEP=1, din=0 three times → dout 7,14,21; key ends at 3.
- Key wrap: key_load with key_in=7, mode=1, din=1 twice → idx 0 then 1 → dout 7 then 14.
- Backpressure: out_ready=0, din=2 then din=3 offered → dout holds 21, in_ready=0, second symbol not accepted. Release out_ready → 28 appears one cycle after acceptance.
- Reprogram: prog_start with out_valid=1 → DRAIN, busy=1. Drain, then write 31,30,…,24 → prog_done pulses on the 8th beat. Then mode=0, key=0, din=0 → 31 and din=7 → 24.
- Reset mid-PROG: assert RST after 3 writes → busy=0, out_valid=0, key=0. din=0 → 7, proving the default table was restored.

Source files
------------

// File: rtl/encrip_stream.sv
// encrip_stream
//   Streaming substitution encoder. Each accepted input symbol indexes a
//   programmable table at (din + key) mod 2**DIN_W. The key can rotate by
//   KEY_STEP on every accepted symbol. The table can be rewritten in place
//   through the prog_* port, and reset restores the default table contents.
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   RST         asynchronous active-high reset
//   mode        0 = static key, 1 = key rotates after each accepted symbol
//   key_load    load key_in into the key register (RUN state only)
//   key_in      key value to load
//   in_valid    input symbol valid
//   in_ready    block can accept a symbol (combinational)
//   din         input symbol
//   out_valid   dout holds a code
//   out_ready   downstream accepts dout
//   dout        encoded symbol (registered)
//   prog_start  request table reprogramming (RUN state only)
//   prog_valid  prog_data holds the next table entry
//   prog_data   table entry value
//   prog_done   one-cycle pulse after the last entry is written
//   busy        high while draining or programming
module encrip_stream #(
  parameter int DIN_W    = 3,
  parameter int DOUT_W   = 5,
  parameter int KEY_STEP = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mode,
  input  logic              key_load,
  input  logic [DIN_W-1:0]  key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] dout,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [DOUT_W-1:0] prog_data,
  output logic              prog_done,
  output logic              busy
);

  localparam int DEPTH = 1 << DIN_W;
  localparam logic [DIN_W-1:0] KEY_INC   = DIN_W'(KEY_STEP);
  localparam logic [DIN_W-1:0] ADDR_LAST = DIN_W'(DEPTH - 1);
  localparam logic [DIN_W-1:0] ADDR_ONE  = DIN_W'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PROG
  } state_t;

  state_t state_reg, state_next;

  logic [DIN_W-1:0]  key_reg;
  logic [DIN_W-1:0]  addr_reg;
  logic [DOUT_W-1:0] dout_reg;
  logic              out_valid_reg;
  logic              prog_done_reg;

  // Held in registers rather than block RAM: reset must restore every
  // entry to its default value in the same cycle.
  logic [DOUT_W-1:0] table_reg [DEPTH];

  logic [DIN_W-1:0]  idx;
  logic              accept;
  logic              out_take;
  logic              tbl_we;

  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign prog_done = prog_done_reg;

  assign idx      = din + key_reg;
  assign accept   = in_valid && in_ready;
  assign out_take = out_valid_reg && out_ready;
  assign tbl_we   = (state_reg == ST_PROG) && prog_valid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_RUN: begin
        in_ready = !out_valid_reg || out_ready;
        if (prog_start) begin
          // A symbol accepted this cycle still looks up the current table.
          state_next = out_valid_reg ? ST_DRAIN : ST_PROG;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // No acceptances here, so out_valid falls exactly on a handshake.
        if (!out_valid_reg || out_ready) begin
          state_next = ST_PROG;
        end
      end
      ST_PROG: begin
        busy = 1'b1;
        if (prog_valid && (addr_reg == ADDR_LAST)) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // ------------------------------------------------------- output stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        dout_reg      <= table_reg[idx];
        out_valid_reg <= 1'b1;
      end else if (out_take) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------- key
  // key_load wins over rotation; the symbol accepted in the same cycle
  // has already used the old key through idx.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_reg <= '0;
    end else begin
      if ((state_reg == ST_RUN) && key_load) begin
        key_reg <= key_in;
      end else if (accept && mode) begin
        key_reg <= key_reg + KEY_INC;
      end
    end
  end

  // ------------------------------------------------ programming counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_reg      <= '0;
      prog_done_reg <= 1'b0;
    end else begin
      prog_done_reg <= 1'b0;
      if (tbl_we) begin
        if (addr_reg == ADDR_LAST) begin
          addr_reg      <= '0;
          prog_done_reg <= 1'b1;
        end else begin
          addr_reg <= addr_reg + ADDR_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------- table
  // Default contents: entry i = (7*i + 7) mod 2**DOUT_W.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam int DEF_VAL = (7 * gi + 7) % (1 << DOUT_W);
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          table_reg[gi] <= DOUT_W'(DEF_VAL);
        end else if (tbl_we && (addr_reg == DIN_W'(gi))) begin
          table_reg[gi] <= prog_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_encrip_stream.sv
// Directed testbench for encrip_stream with hand-computed expected codes.
module tb_encrip_stream;

  logic       CLK;
  logic       RST;
  logic       mode;
  logic       key_load;
  logic [2:0] key_in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] dout;
  logic       prog_start;
  logic       prog_valid;
  logic [4:0] prog_data;
  logic       prog_done;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  encrip_stream #(.DIN_W(3), .DOUT_W(5), .KEY_STEP(1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mode       (mode),
    .key_load   (key_load),
    .key_in     (key_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .prog_start (prog_start),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_done  (prog_done),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%0d", tag, got);
    end else begin
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int stat_exp [8] = '{7, 14, 21, 28, 3, 10, 17, 24};

  initial begin
    RST = 1'b1; mode = 1'b0; key_load = 1'b0; key_in = '0;
    in_valid = 1'b0; din = '0; out_ready = 1'b1;
    prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0;
    tick(); tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dout",      32'(dout),      0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_prog_done", 32'(prog_done), 0);
    chk("rst_in_ready",  32'(in_ready),  1);

    // Static mode, one symbol per cycle
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; din = 3'(i);
      tick();
      chk($sformatf("static_dout[%0d]", i), 32'(dout), 32'(stat_exp[i]));
      chk($sformatf("static_vld[%0d]", i), 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("static_drained", 32'(out_valid), 0);

    // Rotate mode: din=0 three times -> 7,14,21, key ends at 3
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din = 3'd0;
      tick();
      chk($sformatf("rot_dout[%0d]", i), 32'(dout), 32'(stat_exp[i]));
    end
    // Key should now be 3: static lookup of din=0 gives table[3]=28
    mode = 1'b0; din = 3'd0;
    tick();
    chk("rot_key_is_3", 32'(dout), 28);
    in_valid = 1'b0;

    // Key wrap: load 7, rotate, din=1 twice -> idx 0 then 1
    key_load = 1'b1; key_in = 3'd7;
    tick();
    key_load = 1'b0; mode = 1'b1;
    in_valid = 1'b1; din = 3'd1;
    tick();
    chk("wrap_dout0", 32'(dout), 7);
    tick();
    chk("wrap_dout1", 32'(dout), 14);
    in_valid = 1'b0; mode = 1'b0;
    key_load = 1'b1; key_in = 3'd0;
    tick();
    key_load = 1'b0;

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; din = 3'd2;
    tick();
    chk("bp_dout_first", 32'(dout), 21);
    chk("bp_in_ready",   32'(in_ready), 0);
    din = 3'd3;
    tick(); tick();
    chk("bp_dout_held",  32'(dout), 21);
    chk("bp_vld_held",   32'(out_valid), 1);
    chk("bp_in_ready2",  32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 1);
    tick();
    chk("bp_dout_second", 32'(dout), 28);
    in_valid = 1'b0;

    // Reprogram with output pending -> DRAIN
    out_ready = 1'b0; prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    chk("drain_busy",     32'(busy), 1);
    chk("drain_in_ready", 32'(in_ready), 0);
    chk("drain_vld",      32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("prog_vld_fell",  32'(out_valid), 0);
    chk("prog_busy",      32'(busy), 1);
    for (int k = 0; k < 8; k++) begin
      prog_valid = 1'b1; prog_data = 5'(31 - k);
      tick();
      chk($sformatf("prog_done[%0d]", k), 32'(prog_done), (k == 7) ? 1 : 0);
    end
    prog_valid = 1'b0;
    chk("prog_busy_off", 32'(busy), 0);
    in_valid = 1'b1; din = 3'd0;
    tick();
    chk("prog_done_pulse_end", 32'(prog_done), 0);
    chk("newtab_din0", 32'(dout), 31);
    din = 3'd7;
    tick();
    chk("newtab_din7", 32'(dout), 24);
    in_valid = 1'b0;
    tick();

    // Reset mid-PROG: key=5, program three entries, then reset
    key_load = 1'b1; key_in = 3'd5;
    tick();
    key_load = 1'b0;
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    chk("rp_busy", 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      prog_valid = 1'b1; prog_data = 5'(k + 1);
      tick();
    end
    prog_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("rp_async_busy", 32'(busy), 0);
    chk("rp_async_vld",  32'(out_valid), 0);
    tick();
    RST = 1'b0;
    in_valid = 1'b1; din = 3'd0;
    tick();
    chk("rp_default_din0", 32'(dout), 7);
    din = 3'd1;
    tick();
    chk("rp_default_din1", 32'(dout), 14);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
